rsc_encoder: RTL and testbench
==============================

// Module: rsc_encoder
// PURPOSE
//   Transmit-side LTE constituent RSC encoder (8-state, g0=13o feedback, g1=15o parity) with
//   3-step trellis termination. Produces the serial soft-symbol stream the siso decoder's front
//   end consumes: per trellis step, one systematic word followed immediately by one parity word.
//   Bits are BPSK-mapped to signed 16-bit soft values. Serves as source and loopback stimulus.
// PARAMETERS
//   AMP          16'sd1024  soft magnitude; bit 0 -> +AMP, bit 1 -> -AMP
//   MAX_BLKLEN   6144       largest accepted block length (info bits)
//   TAIL_LEN     3          termination steps (fixed by 3-bit state; not for override)
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   rst          in   1   asynchronous, active-low reset
//   blklen       in   16  info bits in next block
//   valid_blklen in   1   blklen qualifier; sampled only in IDLE
//   bit_in       in   1   information bit
//   valid_bit    in   1   bit_in qualifier
//   ready_bit    out  1   encoder accepts bit_in this cycle (valid_bit && ready_bit = transfer)
//   out          out  16  signed soft symbol, sys/parity interleaved
//   valid_out    out  1   out qualifier; no backpressure
//   sys_flag     out  1   1 = out is systematic word, 0 = parity word (valid only with valid_out)
//   last_out     out  1   high with final parity word of the last tail step
//   busy         out  1   block in progress (DATA or TAIL)
//   blklen_err   out  1   one-cycle pulse: blklen==0 or >MAX_BLKLEN offered in IDLE
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, shift reg s1..s3=0, counters 0; out=0, valid_out=0,
//     sys_flag=0, last_out=0, busy=0, ready_bit=0, blklen_err=0. Mid-block reset aborts with no
//     further output; next block restarts from clean state.
//   FSM: IDLE -> DATA on valid_blklen with legal blklen (latched; s1..s3 cleared; busy=1 next cycle).
//     Illegal blklen: stay IDLE, pulse blklen_err. valid_blklen in DATA/TAIL ignored.
//     DATA -> TAIL after blklen-th bit accepted; TAIL -> IDLE after 3rd tail parity word issued.
//   Phase bit: each step occupies 2 cycles (phase 0 = sys, phase 1 = parity).
//     ready_bit = (state==DATA) && phase-0 slot free; at most one bit per 2 cycles.
//     If valid_bit low in DATA, valid_out low (gaps permitted only between steps, never between
//     a step's sys and parity words).
//   Step (bit c accepted cycle N): a = c^s2^s3; z = a^s1^s3; s1<=a, s2<=s1, s3<=s2.
//     Cycle N+1: out=map(c), sys_flag=1, valid_out=1. Cycle N+2: out=map(z), sys_flag=0.
//   Tail step (back-to-back, no gaps, begins the cycle after last data parity word):
//     x = s2^s3 (forces a=0); z = s1^s3; shift with a=0. State is 000 after step 3.
//   Total words per block = 2*(blklen+3). last_out asserted only with final word; busy drops the
//     cycle after last_out. New valid_blklen accepted the cycle busy is low.
//   map(b) = b ? -AMP : +AMP, 16-bit two's complement. All outputs registered.
//   Counter: 16-bit accepted-bit count compared to latched blklen; no wrap (MAX_BLKLEN < 2^16).
// TESTING
//   blklen=4, bits 1,0,0,0, AMP=1024 -> 14 words; sys 1,0,0,0,1,0,1 / par all 1; i.e. FC00,FC00,
//     0400,FC00,0400,FC00,0400,FC00,FC00,FC00,0400,FC00,FC00,FC00; last_out on word 14.
//   Same block with valid_bit toggling 1-cycle gaps -> identical word sequence, sys/parity
//     pairs never split, ready_bit never high in phase 1.
//   valid_blklen with blklen=0 then 6145 -> blklen_err pulses twice, busy stays 0, no output.
//   Random 6144-bit block -> 12294 words; sys words equal input bits; encoder state 000 at end;
//     decode via siso chain recovers input at high SNR.
//   rst low mid-DATA (after 10 bits) -> outputs 0 asynchronously; new blklen=4 block afterwards
//     reproduces scenario 1 exactly.
//   valid_blklen asserted during TAIL -> ignored; second block starts only after busy=0.

Source files
------------

// File: rtl/rsc_encoder.sv
// rsc_encoder: LTE constituent RSC encoder (8-state, feedback 13o, parity 15o)
// with 3-step trellis termination. Emits one BPSK soft word per cycle:
// the systematic word of a step is always followed directly by its parity word.
// State bits: s_q[0] = s1 (newest), s_q[1] = s2, s_q[2] = s3 (oldest).
module rsc_encoder #(
  parameter logic signed [15:0] AMP        = 16'sd1024,
  parameter int                 MAX_BLKLEN = 6144,
  localparam int                TAIL_LEN   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] blklen,
  input  logic        valid_blklen,
  input  logic        bit_in,
  input  logic        valid_bit,
  output logic        ready_bit,
  output logic [15:0] out,
  output logic        valid_out,
  output logic        sys_flag,
  output logic        last_out,
  output logic        busy,
  output logic        blklen_err
);

  localparam logic [15:0] MAX_LEN  = 16'(MAX_BLKLEN);
  localparam logic [1:0]  TAIL_END = 2'(TAIL_LEN);
  localparam logic [1:0]  TAIL_FIN = 2'(TAIL_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  s_q, s_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] blklen_q, blklen_d;
  logic [1:0]  tail_cnt_q, tail_cnt_d;
  logic        phase_q, phase_d;
  logic        par_q, par_d;
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        sys_q, sys_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        a_s, z_s, x_s;

  // BPSK mapping: 0 -> +AMP, 1 -> -AMP
  function automatic logic [15:0] bpsk(input logic b);
    logic signed [15:0] v;
    v = b ? -AMP : AMP;
    return v;
  endfunction

  // Next-state logic: block control, trellis step and the registered output word
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    blklen_d   = blklen_q;
    tail_cnt_d = tail_cnt_q;
    phase_d    = phase_q;
    par_d      = par_q;
    out_d      = 16'd0;
    valid_d    = 1'b0;
    sys_d      = 1'b0;
    last_d     = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    a_s        = 1'b0;
    z_s        = 1'b0;
    x_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_blklen) begin
          if ((blklen == 16'd0) || (blklen > MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_DATA;
            blklen_d = blklen;
            s_d      = 3'b000;
            cnt_d    = 16'd0;
            phase_d  = 1'b0;
            ready_d  = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (phase_q) begin
          // parity word of the step whose systematic word went out last cycle
          out_d   = bpsk(par_q);
          valid_d = 1'b1;
          phase_d = 1'b0;
          if (cnt_q == blklen_q) begin
            state_d    = ST_TAIL;
            tail_cnt_d = 2'd0;
          end else begin
            ready_d = 1'b1;
          end
        end else if (ready_q && valid_bit) begin
          a_s     = bit_in ^ s_q[1] ^ s_q[2];
          z_s     = a_s ^ s_q[0] ^ s_q[2];
          s_d     = {s_q[1], s_q[0], a_s};
          out_d   = bpsk(bit_in);
          sys_d   = 1'b1;
          valid_d = 1'b1;
          par_d   = z_s;
          phase_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_TAIL: begin
        if (tail_cnt_q == TAIL_END) begin
          // one idle-output cycle with busy still high so busy falls after last_out
          state_d    = ST_IDLE;
          tail_cnt_d = 2'd0;
        end else if (!phase_q) begin
          // tail input chosen so the feedback bit is zero, flushing the register
          x_s     = s_q[1] ^ s_q[2];
          z_s     = s_q[0] ^ s_q[2];
          s_d     = {s_q[1], s_q[0], 1'b0};
          out_d   = bpsk(x_s);
          sys_d   = 1'b1;
          valid_d = 1'b1;
          par_d   = z_s;
          phase_d = 1'b1;
        end else begin
          out_d      = bpsk(par_q);
          valid_d    = 1'b1;
          phase_d    = 1'b0;
          tail_cnt_d = tail_cnt_q + 2'd1;
          if (tail_cnt_q == TAIL_FIN) begin
            last_d = 1'b1;
          end else begin
            last_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      s_q        <= 3'b000;
      cnt_q      <= 16'd0;
      blklen_q   <= 16'd0;
      tail_cnt_q <= 2'd0;
      phase_q    <= 1'b0;
      par_q      <= 1'b0;
      out_q      <= 16'd0;
      valid_q    <= 1'b0;
      sys_q      <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      blklen_q   <= blklen_d;
      tail_cnt_q <= tail_cnt_d;
      phase_q    <= phase_d;
      par_q      <= par_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      sys_q      <= sys_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign out        = out_q;
  assign valid_out  = valid_q;
  assign sys_flag   = sys_q;
  assign last_out   = last_q;
  assign busy       = busy_q;
  assign ready_bit  = ready_q;
  assign blklen_err = err_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// tb_rsc_encoder: random and directed blocks checked word-by-word against a
// polynomial-form RSC model (g0 = 1+D^2+D^3, g1 = 1+D+D^3) kept in the bench.
module tb_rsc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] blklen;
  logic        valid_blklen;
  logic        bit_in;
  logic        valid_bit;
  logic        ready_bit;
  logic [15:0] out;
  logic        valid_out;
  logic        sys_flag;
  logic        last_out;
  logic        busy;
  logic        blklen_err;

  rsc_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .blklen       (blklen),
    .valid_blklen (valid_blklen),
    .bit_in       (bit_in),
    .valid_bit    (valid_bit),
    .ready_bit    (ready_bit),
    .out          (out),
    .valid_out    (valid_out),
    .sys_flag     (sys_flag),
    .last_out     (last_out),
    .busy         (busy),
    .blklen_err   (blklen_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] w;
    logic        sys;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    a_hist[$];
  int    g0c[4] = '{1, 0, 1, 1};
  int    g1c[4] = '{1, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mapb(input int b);
    int v;
    v = (b != 0) ? -1024 : 1024;
    return 16'(v);
  endfunction

  task automatic model_reset();
    a_hist = '{0, 0, 0};
  endtask

  // One trellis step from the generator polynomials; tail steps pick the input that zeroes feedback
  task automatic model_step(input int c, input bit tail, input bit last);
    int n;
    int fb;
    int cc;
    int a;
    int z;
    n  = a_hist.size();
    fb = 0;
    for (int i = 1; i < 4; i++) fb = fb ^ (g0c[i] & a_hist[n - i]);
    cc = tail ? fb : c;
    a  = cc ^ fb;
    a_hist.push_back(a);
    n = n + 1;
    z = 0;
    for (int i = 0; i < 4; i++) z = z ^ (g1c[i] & a_hist[n - 1 - i]);
    exp_q.push_back('{mapb(cc), 1'b1, 1'b0});
    exp_q.push_back('{mapb(z), 1'b0, last});
  endtask

  task automatic model_tail();
    for (int t = 0; t < 3; t++) model_step(0, 1'b1, t == 2);
  endtask

  // Output monitor: every valid word is popped from the model queue and compared
  always @(negedge clk) begin : mon
    word_t e;
    bit prev_sys;
    bit prev_last;
    cyc++;
    if (!rst) begin
      prev_sys  = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (prev_sys) chk("pair_split", {31'd0, valid_out && !sys_flag}, 32'd1);
      if (prev_last) chk("busy_after_last", {31'd0, busy}, 32'd0);
      if (valid_out) begin
        if (sys_flag) chk("ready_in_phase1", {31'd0, ready_bit}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none t=%0t", out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word", {16'd0, out}, {16'd0, e.w});
          chk("sys_flag", {31'd0, sys_flag}, {31'd0, e.sys});
          chk("last_out", {31'd0, last_out}, {31'd0, e.last});
          if (last_out) chk("busy_on_last", {31'd0, busy}, 32'd1);
          words_seen++;
        end
      end
      prev_sys  = valid_out && sys_flag;
      prev_last = valid_out && last_out;
    end
  end

  task automatic start_block(input int len);
    blklen       = 16'(len);
    valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("ready_start", {31'd0, ready_bit}, 32'd1);
  endtask

  // mode 0: valid always high; 1: periodic gaps; 2: random gaps
  task automatic send_bits(input int bits[$], input int mode);
    for (int k = 0; k < bits.size(); k++) begin
      bit done;
      int waited;
      bit want;
      done   = 1'b0;
      waited = 0;
      while (!done) begin
        if (mode == 0) want = 1'b1;
        else if (mode == 1) want = (cyc % 3) != 0;
        else want = 1'($urandom_range(0, 1));
        valid_bit = want;
        bit_in    = 1'(bits[k]);
        if (want && ready_bit) begin
          model_step(bits[k], 1'b0, 1'b0);
          done = 1'b1;
        end
        @(negedge clk);
        waited++;
        if (!done && waited > 50) begin
          checks++;
          errors++;
          $display("FAIL bit_timeout actual=no_transfer required=transfer bit=%0d", k);
          valid_bit = 1'b0;
          return;
        end
      end
    end
    valid_bit = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("block_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_block(input int bits[$], input int mode, input bit poke);
    int w0;
    model_reset();
    w0 = words_seen;
    start_block(bits.size());
    send_bits(bits, mode);
    model_tail();
    if (poke) begin
      repeat (2) @(negedge clk);
      blklen       = 16'd4;
      valid_blklen = 1'b1;
      repeat (2) @(negedge clk);
      valid_blklen = 1'b0;
    end
    wait_idle();
    chk("word_count", words_seen - w0, 2 * (bits.size() + 3));
    chk("queue_drained", exp_q.size(), 32'd0);
    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        chk("tail_poke_ignored", {31'd0, busy}, 32'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic bad_len(input int len);
    blklen       = 16'(len);
    valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
    chk("err_pulse", {31'd0, blklen_err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("err_clear", {31'd0, blklen_err}, 32'd0);
    chk("err_no_out", {31'd0, valid_out}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {16'd0, out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_sys"}, {31'd0, sys_flag}, 32'd0);
    chk({tag, "_last"}, {31'd0, last_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready_bit}, 32'd0);
    chk({tag, "_err"}, {31'd0, blklen_err}, 32'd0);
  endtask

  logic [15:0] pin_w[14] = '{16'hFC00, 16'hFC00, 16'h0400, 16'hFC00, 16'h0400, 16'hFC00, 16'h0400,
                             16'hFC00, 16'hFC00, 16'hFC00, 16'h0400, 16'hFC00, 16'hFC00, 16'hFC00};

  initial begin
    int s1[$];
    int rb[$];
    int big[$];
    word_t e;
    rst          = 1'b0;
    blklen       = 16'd0;
    valid_blklen = 1'b0;
    bit_in       = 1'b0;
    valid_bit    = 1'b0;
    s1 = '{1, 0, 0, 0};

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // pin the model against the hand-computed 4-bit block
    model_reset();
    foreach (s1[i]) model_step(s1[i], 1'b0, 1'b0);
    model_tail();
    for (int i = 0; i < 14; i++) begin
      e = exp_q.pop_front();
      chk("pin_word", {16'd0, e.w}, {16'd0, pin_w[i]});
      chk("pin_last", {31'd0, e.last}, {31'd0, i == 13});
    end

    @(negedge clk);
    run_block(s1, 0, 1'b0);
    run_block(s1, 1, 1'b0);

    bad_len(0);
    bad_len(6145);

    rb = '{1};
    run_block(rb, 2, 1'b0);
    for (int b = 0; b < 6; b++) begin
      int len;
      rb.delete();
      len = $urandom_range(2, 40);
      for (int i = 0; i < len; i++) rb.push_back(int'($urandom_range(0, 1)));
      run_block(rb, 2, b == 3);
    end

    // abort mid-DATA, then the scenario-1 block must come out unchanged
    rb.delete();
    for (int i = 0; i < 10; i++) rb.push_back(int'($urandom_range(0, 1)));
    model_reset();
    start_block(20);
    send_bits(rb, 0);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("abort");
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    run_block(s1, 0, 1'b0);

    // largest legal block
    for (int i = 0; i < 6144; i++) big.push_back(int'($urandom_range(0, 1)));
    run_block(big, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
